// File: rtl/game_flow_controller.sv
// Top-level game sequencer: idle -> difficulty select -> countdown -> play/pause -> game over.
// Gates the difficulty selector and game core, and maps the latched level to a step period.
module game_flow_controller #(
    parameter int          TICK_CYCLES = 100_000_000,
    parameter int          COUNT_SECS  = 3,
    parameter int          OVER_SECS   = 5,
    parameter logic [23:0] SLOW_PERIOD = 24'd10_000_000,
    parameter logic [23:0] MED_PERIOD  = 24'd6_000_000,
    parameter logic [23:0] FAST_PERIOD = 24'd3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ir,
    input  logic        sel_done,
    input  logic [1:0]  sel_level,
    input  logic        game_over,
    output logic        sel_reset,
    output logic        game_reset,
    output logic        game_run,
    output logic [1:0]  level,
    output logic [23:0] step_period,
    output logic [1:0]  countdown,
    output logic [2:0]  state
);

    localparam int             TW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int             OW         = $clog2(OVER_SECS + 1);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_CYCLES - 1);
    localparam logic [OW-1:0]  OVER_LAST  = OW'(OVER_SECS - 1);
    localparam logic [1:0]     COUNT_INIT = 2'(COUNT_SECS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SELECT    = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_PAUSE     = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    logic [2:0]    state_reg, state_next;
    logic          combo_q_reg;
    logic          armed_reg, armed_next;
    logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
    logic [OW-1:0] over_cnt_reg, over_cnt_next;
    logic [1:0]    countdown_reg, countdown_next;
    logic [1:0]    level_reg, level_next;
    logic [23:0]   step_period_reg;
    logic          sel_reset_reg, game_reset_reg, game_run_reg;

    logic combo, combo_rise, tick;

    // Combo is the two upper sensors together; the lower two take no part in flow control.
    assign combo      = ((ir & 4'b1100) == 4'b1100);
    assign combo_rise = combo & ~combo_q_reg;
    assign tick       = (tick_cnt_reg == TICK_LAST);

    always_comb begin
        state_next     = state_reg;
        armed_next     = armed_reg;
        over_cnt_next  = over_cnt_reg;
        countdown_next = countdown_reg;
        level_next     = level_reg;
        tick_cnt_next  = '0;

        case (state_reg)
            S_IDLE: begin
                // Wait for the combo to be released so the selector never sees it held.
                if (armed_reg && !combo) begin
                    state_next = S_SELECT;
                    armed_next = 1'b0;
                end else if (combo_rise) begin
                    armed_next = 1'b1;
                end
            end
            S_SELECT: begin
                if (sel_done) begin
                    level_next     = (sel_level == 2'd3) ? 2'd2 : sel_level;
                    countdown_next = COUNT_INIT;
                    state_next     = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    if (countdown_reg <= 2'd1) begin
                        countdown_next = 2'd0;
                        state_next     = S_PLAY;
                    end else begin
                        countdown_next = countdown_reg - 2'd1;
                    end
                end
            end
            S_PLAY: begin
                if (game_over)       state_next = S_OVER;
                else if (combo_rise) state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (combo_rise) state_next = S_PLAY;
            end
            S_OVER: begin
                if (combo_rise) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (over_cnt_reg == OVER_LAST) state_next = S_IDLE;
                    else                           over_cnt_next = over_cnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Counters restart on every state entry and idle at zero outside their states.
        if ((state_next == S_COUNTDOWN || state_next == S_OVER) && state_next == state_reg)
            tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
        if (state_next != S_OVER || state_reg != S_OVER)
            over_cnt_next = '0;
        if (state_next != S_IDLE)
            armed_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            combo_q_reg     <= 1'b1;
            armed_reg       <= 1'b0;
            tick_cnt_reg    <= '0;
            over_cnt_reg    <= '0;
            countdown_reg   <= 2'd0;
            level_reg       <= 2'd0;
            step_period_reg <= SLOW_PERIOD;
            sel_reset_reg   <= 1'b1;
            game_reset_reg  <= 1'b1;
            game_run_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            combo_q_reg   <= combo;
            armed_reg     <= armed_next;
            tick_cnt_reg  <= tick_cnt_next;
            over_cnt_reg  <= over_cnt_next;
            countdown_reg <= countdown_next;
            level_reg     <= level_next;
            case (level_reg)
                2'd0:    step_period_reg <= SLOW_PERIOD;
                2'd1:    step_period_reg <= MED_PERIOD;
                default: step_period_reg <= FAST_PERIOD;
            endcase
            // Outputs are decoded from the next state so they line up with the state register.
            sel_reset_reg  <= (state_next != S_SELECT);
            game_reset_reg <= (state_next == S_IDLE) || (state_next == S_SELECT) ||
                              (state_next == S_COUNTDOWN);
            game_run_reg   <= (state_next == S_PLAY);
        end
    end

    assign state       = state_reg;
    assign sel_reset   = sel_reset_reg;
    assign game_reset  = game_reset_reg;
    assign game_run    = game_run_reg;
    assign level       = level_reg;
    assign step_period = step_period_reg;
    assign countdown   = countdown_reg;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: table of timed input steps with expected outputs fed
// through a scoreboard queue, plus a hand-written illegal-state sequence.
module tb_game_flow_controller;

    localparam int          T    = 10;
    localparam logic [23:0] SLOW = 24'd10_000_000;
    localparam logic [23:0] MED  = 24'd6_000_000;
    localparam logic [23:0] FAST = 24'd3_000_000;
    localparam logic [3:0]  C    = 4'b1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ir;
    logic        sel_done;
    logic [1:0]  sel_level;
    logic        game_over;
    logic        sel_reset, game_reset, game_run;
    logic [1:0]  level, countdown;
    logic [23:0] step_period;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    game_flow_controller #(
        .TICK_CYCLES(T), .COUNT_SECS(3), .OVER_SECS(5),
        .SLOW_PERIOD(SLOW), .MED_PERIOD(MED), .FAST_PERIOD(FAST)
    ) dut (
        .clk(clk), .reset(reset), .ir(ir), .sel_done(sel_done), .sel_level(sel_level),
        .game_over(game_over), .sel_reset(sel_reset), .game_reset(game_reset),
        .game_run(game_run), .level(level), .step_period(step_period),
        .countdown(countdown), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ir;
        logic        sd;
        logic [1:0]  sl;
        logic        go;
        int          cyc;
        logic [2:0]  st;
        logic        selr;
        logic        gres;
        logic        run;
        logic [1:0]  lvl;
        logic [1:0]  cd;
        logic [23:0] sp;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic r, logic [3:0] i, logic d, logic [1:0] l, logic g, int n,
                                logic [2:0] st, logic sr, logic gr, logic rn,
                                logic [1:0] lv, logic [1:0] cd, logic [23:0] sp);
        vec_t v;
        v.rst = r; v.ir = i; v.sd = d; v.sl = l; v.go = g; v.cyc = n;
        v.st = st; v.selr = sr; v.gres = gr; v.run = rn; v.lvl = lv; v.cd = cd; v.sp = sp;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        // rst ir sd sl go cyc | state selr gres run lvl cd step
        vecs.push_back(mk(1, C, 0, 0, 0, 2,     0, 1, 1, 0, 0, 0, SLOW)); // reset with combo held
        vecs.push_back(mk(0, C, 0, 0, 0, 3,     0, 1, 1, 0, 0, 0, SLOW)); // held combo: no rise
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,     0, 1, 1, 0, 0, 0, SLOW));
        vecs.push_back(mk(0, C, 0, 0, 0, 1,     0, 1, 1, 0, 0, 0, SLOW)); // arm
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,     1, 0, 1, 0, 0, 0, SLOW)); // release -> SELECT
        vecs.push_back(mk(0, 0, 0, 2, 0, 3,     1, 0, 1, 0, 0, 0, SLOW));
        vecs.push_back(mk(0, 0, 1, 2, 0, 1,     2, 1, 1, 0, 2, 3, SLOW)); // latch level 2
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     2, 1, 1, 0, 2, 3, FAST)); // period one cycle later
        vecs.push_back(mk(0, 0, 0, 2, 0, T-2,   2, 1, 1, 0, 2, 3, FAST));
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     2, 1, 1, 0, 2, 2, FAST)); // first tick
        vecs.push_back(mk(0, 0, 0, 2, 0, T,     2, 1, 1, 0, 2, 1, FAST));
        vecs.push_back(mk(0, 0, 0, 2, 0, T-1,   2, 1, 1, 0, 2, 1, FAST)); // one short of PLAY
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     3, 1, 0, 1, 2, 0, FAST)); // PLAY at 3T+1
        vecs.push_back(mk(0, C, 0, 2, 0, 1,     4, 1, 0, 0, 2, 0, FAST)); // pause
        vecs.push_back(mk(0, C, 0, 2, 0, 3,     4, 1, 0, 0, 2, 0, FAST)); // held stays paused
        vecs.push_back(mk(0, 0, 0, 2, 1, 1,     4, 1, 0, 0, 2, 0, FAST)); // game_over ignored
        vecs.push_back(mk(0, C, 0, 2, 0, 1,     3, 1, 0, 1, 2, 0, FAST)); // resume
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     3, 1, 0, 1, 2, 0, FAST));
        vecs.push_back(mk(0, C, 0, 2, 1, 1,     5, 1, 0, 0, 2, 0, FAST)); // over beats pause
        vecs.push_back(mk(0, C, 0, 2, 0, 5*T-1, 5, 1, 0, 0, 2, 0, FAST));
        vecs.push_back(mk(0, C, 0, 2, 0, 1,     0, 1, 1, 0, 2, 0, FAST)); // timeout, level kept
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     0, 1, 1, 0, 2, 0, FAST));
        vecs.push_back(mk(0, C, 0, 2, 0, 1,     0, 1, 1, 0, 2, 0, FAST));
        vecs.push_back(mk(0, 0, 0, 2, 0, 1,     1, 0, 1, 0, 2, 0, FAST));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1,     2, 1, 1, 0, 1, 3, FAST)); // level 1
        vecs.push_back(mk(0, 0, 0, 1, 0, 1,     2, 1, 1, 0, 1, 3, MED));
        vecs.push_back(mk(0, 0, 0, 1, 0, T,     2, 1, 1, 0, 1, 2, MED));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1,     0, 1, 1, 0, 0, 0, SLOW)); // reset mid-countdown
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,     0, 1, 1, 0, 0, 0, SLOW));
        vecs.push_back(mk(0, C, 0, 0, 0, 1,     0, 1, 1, 0, 0, 0, SLOW));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,     1, 0, 1, 0, 0, 0, SLOW));
        vecs.push_back(mk(0, 0, 1, 3, 0, 1,     2, 1, 1, 0, 2, 3, SLOW)); // level 3 -> 2
        vecs.push_back(mk(0, 0, 0, 3, 0, 1,     2, 1, 1, 0, 2, 3, FAST));
        vecs.push_back(mk(0, 0, 0, 3, 0, 3*T-1, 3, 1, 0, 1, 2, 0, FAST));
        vecs.push_back(mk(0, 0, 0, 3, 1, 1,     5, 1, 0, 0, 2, 0, FAST));
        vecs.push_back(mk(0, C, 0, 3, 0, 1,     0, 1, 1, 0, 2, 0, FAST)); // combo exits OVER
        vecs.push_back(mk(0, C, 0, 3, 0, 2,     0, 1, 1, 0, 2, 0, FAST));
        vecs.push_back(mk(0, 0, 0, 3, 0, 1,     0, 1, 1, 0, 2, 0, FAST)); // not armed

        reset = 1'b1; ir = 4'b0; sel_done = 1'b0; sel_level = 2'd0; game_over = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v, e;
            v = vecs[i];
            reset = v.rst; ir = v.ir; sel_done = v.sd; sel_level = v.sl; game_over = v.go;
            exp_q.push_back(v);
            repeat (v.cyc) @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("step %0d: state=%0d sel_reset=%0d game_reset=%0d game_run=%0d level=%0d countdown=%0d step_period=%0d",
                     i, state, sel_reset, game_reset, game_run, level, countdown, step_period);
            chk("state",       i, 32'(state),       32'(e.st));
            chk("sel_reset",   i, 32'(sel_reset),   32'(e.selr));
            chk("game_reset",  i, 32'(game_reset),  32'(e.gres));
            chk("game_run",    i, 32'(game_run),    32'(e.run));
            chk("level",       i, 32'(level),       32'(e.lvl));
            chk("countdown",   i, 32'(countdown),   32'(e.cd));
            chk("step_period", i, 32'(step_period), 32'(e.sp));
        end

        // Illegal state code recovers to IDLE on the next clock.
        ir = 4'b0; sel_done = 1'b0; game_over = 1'b0;
        force dut.state_reg = 3'd7;
        #1;
        chk("forced_state", 100, 32'(state), 32'd7);
        release dut.state_reg;
        @(posedge clk); #1;
        $display("illegal: state=%0d sel_reset=%0d game_reset=%0d", state, sel_reset, game_reset);
        chk("illegal_recover", 101, 32'(state),      32'd0);
        chk("illegal_selr",    101, 32'(sel_reset),  32'd1);
        chk("illegal_gres",    101, 32'(game_reset), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
